// File: rtl/fetch1.sv
// Front-end PC generator: issues a word-aligned slot-0/slot-1 fetch address pair
// each cycle and registers the side-band that travels with it to fetch2.
module fetch1 #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clock_i,
  input  logic        reset_n_i,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  input  logic        pred_taken_0_i,
  input  logic        pred_taken_1_i,
  input  logic [31:0] pred_target_i,
  output logic [31:0] iaddr0_o,
  output logic [31:0] iaddr1_o,
  output logic        fetch_valid_o,
  output logic [31:0] pc0_o,
  output logic [31:0] pc1_o,
  output logic        pred_0_o,
  output logic        pred_1_o,
  output logic        zero_1_o
);

  localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

  logic [31:0] pc_r;
  logic [31:0] pc_plus4_s;
  logic [31:0] next_pc_s;
  logic        pred_0_eff_s;
  logic        pred_1_eff_s;
  logic        update_s;
  logic        fetch_valid_r;
  logic [31:0] pc0_r;
  logic [31:0] pc1_r;
  logic        pred_0_r;
  logic        pred_1_r;
  logic        zero_1_r;

  assign pc_plus4_s = pc_r + 32'd4;
  assign update_s   = ~stall_i | redirect_i;

  // Predictor bits only count on a normal advancing cycle.
  assign pred_0_eff_s = pred_taken_0_i & ~stall_i & ~redirect_i;
  assign pred_1_eff_s = pred_taken_1_i & ~stall_i & ~redirect_i;

  // Next-PC selection: redirect, stall hold, predicted target, sequential.
  always_comb begin
    next_pc_s = pc_r;
    if (redirect_i) begin
      next_pc_s = {redirect_pc_i[31:2], 2'b00};
    end else if (stall_i) begin
      next_pc_s = pc_r;
    end else if (pred_0_eff_s || pred_1_eff_s) begin
      next_pc_s = {pred_target_i[31:2], 2'b00};
    end else begin
      next_pc_s = pc_r + 32'd8;
    end
  end

  // PC register.
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      pc_r <= RESET_PC_ALIGNED;
    end else begin
      pc_r <= next_pc_s;
    end
  end

  // Side-band for the pair whose data arrives at fetch2 next cycle.
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      pc0_r    <= 32'h0000_0000;
      pc1_r    <= 32'h0000_0000;
      pred_0_r <= 1'b0;
      pred_1_r <= 1'b0;
      zero_1_r <= 1'b0;
    end else if (update_s) begin
      pc0_r    <= pc_r;
      pc1_r    <= pc_plus4_s;
      pred_0_r <= pred_0_eff_s;
      zero_1_r <= pred_0_eff_s;
      pred_1_r <= pred_1_eff_s & ~pred_0_eff_s;
    end
  end

  // Valid flag: a redirect kills the wrong-path pair in flight.
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      fetch_valid_r <= 1'b0;
    end else if (redirect_i) begin
      fetch_valid_r <= 1'b0;
    end else if (!stall_i) begin
      fetch_valid_r <= 1'b1;
    end
  end

  assign iaddr0_o      = pc_r;
  assign iaddr1_o      = pc_plus4_s;
  assign fetch_valid_o = fetch_valid_r;
  assign pc0_o         = pc0_r;
  assign pc1_o         = pc1_r;
  assign pred_0_o      = pred_0_r;
  assign pred_1_o      = pred_1_r;
  assign zero_1_o      = zero_1_r;

endmodule

// File: tb/tb_fetch1.sv
// Directed bench for fetch1: sequential fetch, prediction steering, redirect bubble,
// stall hold, address wrap and asynchronous reset.
module tb_fetch1;

  logic        clock_s;
  logic        reset_n_s;
  logic        stall_s;
  logic        redirect_s;
  logic [31:0] redirect_pc_s;
  logic        pred_taken_0_s;
  logic        pred_taken_1_s;
  logic [31:0] pred_target_s;
  logic [31:0] iaddr0_s;
  logic [31:0] iaddr1_s;
  logic        fetch_valid_s;
  logic [31:0] pc0_s;
  logic [31:0] pc1_s;
  logic        pred_0_s;
  logic        pred_1_s;
  logic        zero_1_s;

  int vectors_r;
  int miscompares_r;

  fetch1 #(.RESET_PC(32'h0000_0100)) dut (
    .clock_i       (clock_s),
    .reset_n_i     (reset_n_s),
    .stall_i       (stall_s),
    .redirect_i    (redirect_s),
    .redirect_pc_i (redirect_pc_s),
    .pred_taken_0_i(pred_taken_0_s),
    .pred_taken_1_i(pred_taken_1_s),
    .pred_target_i (pred_target_s),
    .iaddr0_o      (iaddr0_s),
    .iaddr1_o      (iaddr1_s),
    .fetch_valid_o (fetch_valid_s),
    .pc0_o         (pc0_s),
    .pc1_o         (pc1_s),
    .pred_0_o      (pred_0_s),
    .pred_1_o      (pred_1_s),
    .zero_1_o      (zero_1_s)
  );

  initial clock_s = 1'b0;
  always #5 clock_s = ~clock_s;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors_r++;
    assert (obs === exp) else begin
      miscompares_r++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle before sampling.
  task automatic step();
    @(posedge clock_s);
    #1;
  endtask

  task automatic clear_inputs();
    stall_s        = 1'b0;
    redirect_s     = 1'b0;
    redirect_pc_s  = 32'h0000_0000;
    pred_taken_0_s = 1'b0;
    pred_taken_1_s = 1'b0;
    pred_target_s  = 32'h0000_0000;
  endtask

  initial begin
    vectors_r     = 0;
    miscompares_r = 0;
    clear_inputs();
    reset_n_s = 1'b0;
    #12;
    chk("rst_iaddr0", iaddr0_s, 32'h0000_0100);
    chk("rst_iaddr1", iaddr1_s, 32'h0000_0104);
    chk("rst_valid", {31'd0, fetch_valid_s}, 32'd0);
    chk("rst_pc0", pc0_s, 32'h0000_0000);
    reset_n_s = 1'b1;

    // Sequential fetch
    step();
    chk("seq1_iaddr0", iaddr0_s, 32'h0000_0108);
    chk("seq1_pc0", pc0_s, 32'h0000_0100);
    chk("seq1_pc1", pc1_s, 32'h0000_0104);
    chk("seq1_valid", {31'd0, fetch_valid_s}, 32'd1);
    step();
    chk("seq2_iaddr0", iaddr0_s, 32'h0000_0110);
    chk("seq2_pc0", pc0_s, 32'h0000_0108);

    // Redirect to 0x200, then slot-0 predicted taken to 0x404
    redirect_s = 1'b1; redirect_pc_s = 32'h0000_0200;
    step();
    chk("rd200_iaddr0", iaddr0_s, 32'h0000_0200);
    chk("rd200_valid", {31'd0, fetch_valid_s}, 32'd0);
    clear_inputs();
    pred_taken_0_s = 1'b1; pred_target_s = 32'h0000_0404;
    step();
    chk("p0_iaddr0", iaddr0_s, 32'h0000_0404);
    chk("p0_iaddr1", iaddr1_s, 32'h0000_0408);
    chk("p0_zero1", {31'd0, zero_1_s}, 32'd1);
    chk("p0_pred0", {31'd0, pred_0_s}, 32'd1);
    chk("p0_pred1", {31'd0, pred_1_s}, 32'd0);
    chk("p0_pc0", pc0_s, 32'h0000_0200);
    chk("p0_valid", {31'd0, fetch_valid_s}, 32'd1);

    // Back to 0x200, slot-1 predicted taken to 0x300
    clear_inputs();
    redirect_s = 1'b1; redirect_pc_s = 32'h0000_0200;
    step();
    clear_inputs();
    pred_taken_1_s = 1'b1; pred_target_s = 32'h0000_0300;
    step();
    chk("p1_iaddr0", iaddr0_s, 32'h0000_0300);
    chk("p1_zero1", {31'd0, zero_1_s}, 32'd0);
    chk("p1_pred1", {31'd0, pred_1_s}, 32'd1);
    chk("p1_pred0", {31'd0, pred_0_s}, 32'd0);

    // Redirect beats simultaneous stall and prediction; low bits dropped
    clear_inputs();
    redirect_s = 1'b1; redirect_pc_s = 32'h0000_1003;
    stall_s = 1'b1; pred_taken_0_s = 1'b1; pred_target_s = 32'h0000_0404;
    step();
    chk("rdst_iaddr0", iaddr0_s, 32'h0000_1000);
    chk("rdst_valid", {31'd0, fetch_valid_s}, 32'd0);
    chk("rdst_zero1", {31'd0, zero_1_s}, 32'd0);
    clear_inputs();
    step();
    chk("rdst2_valid", {31'd0, fetch_valid_s}, 32'd1);
    chk("rdst2_pc0", pc0_s, 32'h0000_1000);
    chk("rdst2_iaddr0", iaddr0_s, 32'h0000_1008);

    // Reach PC=0x40 with valid output, then stall 3 cycles
    redirect_s = 1'b1; redirect_pc_s = 32'h0000_0038;
    step();
    clear_inputs();
    step();
    chk("pre_st_iaddr0", iaddr0_s, 32'h0000_0040);
    stall_s = 1'b1; pred_taken_0_s = 1'b1; pred_target_s = 32'h0000_0800;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("st_iaddr0", iaddr0_s, 32'h0000_0040);
      chk("st_pc0", pc0_s, 32'h0000_0038);
      chk("st_valid", {31'd0, fetch_valid_s}, 32'd1);
      chk("st_zero1", {31'd0, zero_1_s}, 32'd0);
    end
    clear_inputs();
    step();
    chk("st_rel_iaddr0", iaddr0_s, 32'h0000_0048);
    chk("st_rel_pc0", pc0_s, 32'h0000_0040);

    // Address wrap at top of memory
    redirect_s = 1'b1; redirect_pc_s = 32'hFFFF_FFF8;
    step();
    clear_inputs();
    chk("wr_iaddr0", iaddr0_s, 32'hFFFF_FFF8);
    chk("wr_iaddr1", iaddr1_s, 32'hFFFF_FFFC);
    pred_taken_1_s = 1'b1; pred_target_s = 32'h0000_0500;
    step();
    chk("wr2_iaddr0", iaddr0_s, 32'h0000_0500);
    chk("wr2_pc1", pc1_s, 32'hFFFF_FFFC);
    clear_inputs();
    step();
    chk("wr3_pc0", pc0_s, 32'h0000_0500);
    redirect_s = 1'b1; redirect_pc_s = 32'hFFFF_FFF8;
    step();
    clear_inputs();
    step();
    chk("wrap_iaddr0", iaddr0_s, 32'h0000_0000);
    chk("wrap_iaddr1", iaddr1_s, 32'h0000_0004);
    chk("wrap_pc0", pc0_s, 32'hFFFF_FFF8);
    chk("wrap_valid", {31'd0, fetch_valid_s}, 32'd1);

    // Asynchronous reset mid-cycle
    #2;
    reset_n_s = 1'b0;
    #1;
    chk("arst_iaddr0", iaddr0_s, 32'h0000_0100);
    chk("arst_valid", {31'd0, fetch_valid_s}, 32'd0);
    chk("arst_pc0", pc0_s, 32'h0000_0000);
    chk("arst_pc1", pc1_s, 32'h0000_0000);
    reset_n_s = 1'b1;
    step();
    chk("post_iaddr0", iaddr0_s, 32'h0000_0108);
    chk("post_valid", {31'd0, fetch_valid_s}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors_r, miscompares_r);
    $finish;
  end

endmodule
